// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: combinational grant to a single memory port, RD_LAT-cycle read return.
// Optional macro MEM_ARBITER_ROUND_ROBIN_EN enables round-robin arbitration; default is fixed priority to port 0.
//
// state   | meaning
// IDLE    | no read outstanding, arbitrating every cycle
// RD_WAIT | read outstanding; cnt counts down to the return cycle (cnt==0)
module mem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       owner, owner_nxt;
  logic       arb_ok, any_gnt, sel1, rd_done;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // ptr names the port favoured in the next conflict
  logic ptr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= 1'b0;
    end else if (any_gnt) begin
      ptr <= ~sel1;
    end
  end

  assign sel1 = (m0_req_i && m1_req_i) ? ptr : (m1_req_i && !m0_req_i);
`else
  assign sel1 = m1_req_i && !m0_req_i;
`endif

  // outputs are forced low while reset is held, even with requests pending
  assign arb_ok  = rst_ni && ((state == IDLE) || (cnt == 3'd0));
  assign any_gnt = arb_ok && (m0_req_i || m1_req_i);
  assign rd_done = rst_ni && (state == RD_WAIT) && (cnt == 3'd0);

  assign m0_gnt_o    = any_gnt && !sel1;
  assign m1_gnt_o    = any_gnt && sel1;
  assign mem_en_o    = any_gnt;
  assign mem_we_o    = any_gnt && (sel1 ? m1_we_i : m0_we_i);
  assign mem_addr_o  = any_gnt ? (sel1 ? m1_addr_i : m0_addr_i) : '0;
  assign mem_wdata_o = any_gnt ? (sel1 ? m1_wdata_i : m0_wdata_i) : '0;

  assign m0_rvalid_o = rd_done && !owner;
  assign m1_rvalid_o = rd_done && owner;
  assign m0_rdata_o  = mem_rdata_i;
  assign m1_rdata_o  = mem_rdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= 3'd0;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    owner_nxt = owner;
    if (state == RD_WAIT) begin
      if (cnt != 3'd0) begin
        cnt_nxt = cnt - 3'd1;
      end else begin
        state_nxt = IDLE;
      end
    end
    // a read granted in the return cycle chains straight into a new wait
    if (any_gnt && !mem_we_o) begin
      state_nxt = RD_WAIT;
      cnt_nxt   = LAT_M1;
      owner_nxt = sel1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; RD_LAT=1/7 instances share stimulus for the latency check.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk, rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, mem_rdata;

  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_en, mem_we;
  logic [DW-1:0] m0_rdata, m1_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  logic          a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_mem_en, a_mem_we;
  logic [DW-1:0] a_m0_rdata, a_m1_rdata, a_mem_wdata;
  logic [AW-1:0] a_mem_addr;
  logic          b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_en, b_mem_we;
  logic [DW-1:0] b_m0_rdata, b_m1_rdata, b_mem_wdata;
  logic [AW-1:0] b_mem_addr;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut_lat1 (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(a_m0_gnt), .m0_rvalid_o(a_m0_rvalid), .m0_rdata_o(a_m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(a_m1_gnt), .m1_rvalid_o(a_m1_rvalid), .m1_rdata_o(a_m1_rdata),
    .mem_en_o(a_mem_en), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(7)) dut_lat7 (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(b_m0_gnt), .m0_rvalid_o(b_m0_rvalid), .m0_rdata_o(b_m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(b_m1_gnt), .m1_rvalid_o(b_m1_rvalid), .m1_rdata_o(b_m1_rdata),
    .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // inputs change just after the rising edge, outputs are sampled on the falling edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_g1;
    idle_inputs();
    rst_n = 0;
    mem_rdata = 32'hDEADBEEF;

    // reset: requests present but every output held low
    m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_we = 1; m1_wdata = 32'h55;
    @(negedge clk);
    check("rst_gnt0", m0_gnt, 0);
    check("rst_gnt1", m1_gnt, 0);
    check("rst_en", mem_en, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rv", {m0_rvalid, m1_rvalid}, 0);
    idle_inputs();
    next_cycle();
    rst_n = 1;
    @(negedge clk);
    check("idle_en", mem_en, 0);
    check("idle_addr", mem_addr, 0);

    // single read, m1 write blocked at T+1 and granted at T+2
    next_cycle();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    @(negedge clk);
    check("rd_gnt0_T", m0_gnt, 1);
    check("rd_en_T", mem_en, 1);
    check("rd_we_T", mem_we, 0);
    check("rd_addr_T", mem_addr, 32'h10);
    next_cycle();
    m0_req = 0; m1_req = 1; m1_we = 1; m1_addr = 32'h44; m1_wdata = 32'h99;
    @(negedge clk);
    check("rd_gnt_T1", {m0_gnt, m1_gnt}, 0);
    check("rd_en_T1", mem_en, 0);
    check("rd_rv_T1", m0_rvalid, 0);
    next_cycle();
    @(negedge clk);
    check("rd_rv0_T2", m0_rvalid, 1);
    check("rd_rv1_T2", m1_rvalid, 0);
    check("rd_data_T2", m0_rdata, 32'hDEADBEEF);
    check("wr_gnt1_T2", m1_gnt, 1);
    check("wr_we_T2", mem_we, 1);
    check("wr_wdata_T2", mem_wdata, 32'h99);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("rd_rv_T3", {m0_rvalid, m1_rvalid}, 0);

    // simultaneous reads: m0 first, m1 granted in m0's return cycle
    next_cycle();
    m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h200;
    @(negedge clk);
    check("sim_gnt_T", {m0_gnt, m1_gnt}, 2'b10);
    next_cycle();
    m0_req = 0;
    @(negedge clk);
    check("sim_gnt_T1", {m0_gnt, m1_gnt}, 2'b00);
    check("sim_en_T1", mem_en, 0);
    next_cycle();
    @(negedge clk);
    check("sim_rv0_T2", m0_rvalid, 1);
    check("sim_gnt1_T2", m1_gnt, 1);
    check("sim_addr_T2", mem_addr, 32'h200);
    next_cycle();
    m1_req = 0;
    @(negedge clk);
    check("sim_rv_T3", {m0_rvalid, m1_rvalid}, 0);
    next_cycle();
    @(negedge clk);
    check("sim_rv_T4", {m0_rvalid, m1_rvalid}, 2'b01);

    // continuous write conflict; last grant was m1, so m0 wins first
    next_cycle();
    m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      exp_g1 = (i % 2) == 1;
`else
      exp_g1 = 1'b0;
`endif
      @(negedge clk);
      check("prio_gnt1", m1_gnt, exp_g1);
      check("prio_gnt0", m0_gnt, !exp_g1);
      next_cycle();
    end
    idle_inputs();

    // back-to-back writes from m1
    for (int i = 1; i <= 3; i++) begin
      m1_req = 1; m1_we = 1; m1_addr = 32'h20 + i; m1_wdata = i;
      @(negedge clk);
      check("b2b_gnt1", m1_gnt, 1);
      check("b2b_we", mem_we, 1);
      check("b2b_wdata", mem_wdata, i);
      check("b2b_addr", mem_addr, 32'h20 + i);
      check("b2b_rv", {m0_rvalid, m1_rvalid}, 0);
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    check("b2b_idle_en", mem_en, 0);
    check("b2b_idle_wdata", mem_wdata, 0);

    // reset during outstanding read
    next_cycle();
    m0_req = 1; m0_addr = 32'h30;
    @(negedge clk);
    check("rr_gnt_T", m0_gnt, 1);
    next_cycle();
    rst_n = 0; m0_req = 0; m1_req = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rdrst_out", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we}, 0);
      check("rdrst_addr", mem_addr, 0);
      next_cycle();
    end
    rst_n = 1; m1_req = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rdrst_rv", {m0_rvalid, m1_rvalid, a_m0_rvalid, b_m0_rvalid}, 0);
      next_cycle();
    end

    // latency range across RD_LAT=1, 2 and 7
    m0_req = 1; m0_we = 0; m0_addr = 32'h40;
    @(negedge clk);
    check("lat_gnt", {a_m0_gnt, m0_gnt, b_m0_gnt}, 3'b111);
    next_cycle();
    m0_req = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("lat1_rv", a_m0_rvalid, k == 1);
      check("lat2_rv", m0_rvalid, k == 2);
      check("lat7_rv", b_m0_rvalid, k == 7);
      check("lat7_en", b_mem_en, 0);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
